// File: rtl/simon_pkg.sv
// simon_pkg: shared constants and types for the Simon128/256 round-key arbiter
package simon_pkg;
    localparam int SIMON_NUM_ROUNDS     = 72;
    localparam int SIMON_KEY_WIDTH      = 64;
    localparam int SIMON_KEY_ADDR_WIDTH = 9;

    typedef enum logic [1:0] {NO_KEY, KEY_READY, DRAIN} key_arb_state_t;

    typedef struct packed {
        logic       valid;
        logic       err;
        logic [2:0] idx;
    } key_arb_tag_t;
endpackage

// File: rtl/simon_rr_arbiter.sv
// simon_rr_arbiter: one-hot round-robin grant (fixed priority under SIMON_KEY_ARB_FIXED_PRIO_EN)
module simon_rr_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] grant
);
    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] base;
    logic [PW-1:0] ptr_nxt;
    logic [PW:0]   j;

`ifdef SIMON_KEY_ARB_FIXED_PRIO_EN
    logic unused;
    assign unused = ^{clk, rst, ptr_nxt};
    assign base   = '0;
`else
    logic [PW-1:0] ptr;
    assign base = ptr;

    // move the pointer just past the winner; hold it when nothing is granted
    always_ff @(posedge clk) begin
        if (rst) ptr <= '0;
        else if (|grant) ptr <= ptr_nxt;
    end
`endif

    // scan from the highest offset down so the closest requester at or after base wins
    always_comb begin
        grant   = '0;
        ptr_nxt = base;
        j       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = {1'b0, base} + (PW+1)'(k);
            if (j >= (PW+1)'(NUM_REQ)) j = j - (PW+1)'(NUM_REQ);
            if (en && req[j[PW-1:0]]) begin
                grant              = '0;
                grant[j[PW-1:0]]   = 1'b1;
                ptr_nxt            = (j == (PW+1)'(NUM_REQ - 1)) ? '0 : PW'(j + 1'b1);
            end
        end
    end
endmodule

// File: rtl/simon_key_arbiter.sv
// simon_key_arbiter: shares the round-key memory read port among cipher cores; define SIMON_KEY_ARB_FIXED_PRIO_EN for fixed priority
module simon_key_arbiter
    import simon_pkg::*;
#(
    parameter int NUM_REQ     = 2,
    parameter int ADDR_WIDTH  = SIMON_KEY_ADDR_WIDTH,
    parameter int DATA_WIDTH  = SIMON_KEY_WIDTH,
    parameter int NUM_ROUNDS  = SIMON_NUM_ROUNDS,
    parameter int MEM_LATENCY = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          key_compute_start,
    input  logic                          key_mem_full,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          rsp_err,
    output logic [ADDR_WIDTH-1:0]         key_addr,
    output logic                          key_rd_en,
    input  logic [DATA_WIDTH-1:0]         key_data,
    input  logic                          key_data_vld,
    output logic                          keys_ready,
    output logic                          proto_err
);
    key_arb_state_t                state, state_nxt;
    key_arb_tag_t [MEM_LATENCY:0]  pipe;
    key_arb_tag_t                  head, tag_in;
    logic [ADDR_WIDTH-1:0]         gaddr;
    logic [2:0]                    gidx;
    logic                          in_range, pipe_busy;

    assign keys_ready = state == KEY_READY;
    assign head       = pipe[MEM_LATENCY];
    assign in_range   = gaddr < ADDR_WIDTH'(NUM_ROUNDS);
    assign tag_in     = '{valid: |req_ready, err: !in_range, idx: gidx};

    simon_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .clk   (clk),
        .rst   (rst),
        .en    (keys_ready),
        .req   (req_valid),
        .grant (req_ready)
    );

    // select the granted requester's address and note whether any tag is in flight
    always_comb begin
        gaddr     = '0;
        gidx      = '0;
        pipe_busy = 1'b0;
        for (int i = 0; i < NUM_REQ; i++)
            if (req_ready[i]) begin
                gaddr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                gidx  = 3'(i);
            end
        for (int k = 0; k <= MEM_LATENCY; k++) pipe_busy = pipe_busy | pipe[k].valid;
    end

    // key-validity FSM; a new computation always wins over a full memory
    always_comb begin
        state_nxt = state;
        case (state)
            NO_KEY:    state_nxt = (key_mem_full && !key_compute_start) ? KEY_READY : NO_KEY;
            KEY_READY: state_nxt = (key_compute_start || !key_mem_full) ? DRAIN : KEY_READY;
            DRAIN:     state_nxt = pipe_busy ? DRAIN : NO_KEY;
            default:   state_nxt = NO_KEY;
        endcase
    end

    // issue reads, carry tags alongside the memory latency, and route the returning keys
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= NO_KEY;
            pipe      <= '0;
            key_rd_en <= 1'b0;
            key_addr  <= '0;
            rsp_valid <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            proto_err <= 1'b0;
        end else begin
            state     <= state_nxt;
            pipe      <= {pipe[MEM_LATENCY-1:0], tag_in};
            key_rd_en <= |req_ready && in_range;
            if (|req_ready && in_range) key_addr <= gaddr;
            rsp_valid <= head.valid ? NUM_REQ'(1) << head.idx : '0;
            rsp_err   <= head.valid && head.err;
            if (head.valid) rsp_data <= head.err ? '0 : key_data;
            if (key_data_vld != (head.valid && !head.err)) proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_simon_key_arbiter.sv
// tb_simon_key_arbiter: directed self-checking bench for simon_key_arbiter
module tb_simon_key_arbiter;
`ifdef SIMON_KEY_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        key_compute_start = 1'b0;
    logic        key_mem_full = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [17:0] req_addr = '0;
    logic [1:0]  req_ready, rsp_valid;
    logic [63:0] rsp_data;
    logic        rsp_err;
    logic [8:0]  key_addr;
    logic        key_rd_en;
    logic [63:0] key_data = '0;
    logic        key_data_vld = 1'b0;
    logic        keys_ready, proto_err;

    int tests = 0;
    int fails = 0;

    logic       pend = 1'b0;
    logic [8:0] paddr = '0;
    bit         suppress = 1'b0;

    typedef struct {
        int          due;
        int          idx;
        logic [63:0] data;
    } exp_t;

    simon_key_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .key_compute_start (key_compute_start),
        .key_mem_full      (key_mem_full),
        .req_valid         (req_valid),
        .req_addr          (req_addr),
        .req_ready         (req_ready),
        .rsp_valid         (rsp_valid),
        .rsp_data          (rsp_data),
        .rsp_err           (rsp_err),
        .key_addr          (key_addr),
        .key_rd_en         (key_rd_en),
        .key_data          (key_data),
        .key_data_vld      (key_data_vld),
        .keys_ready        (keys_ready),
        .proto_err         (proto_err)
    );

    initial forever #5 clk = ~clk;

    function automatic logic [63:0] key_of(input logic [8:0] a);
        return 64'h0123456789ABCDEF ^ (64'(a ^ 9'd5) * 64'h0001000100010001);
    endfunction

    // key memory with one cycle of latency; can drop a single return on request
    always @(negedge clk) begin
        key_data_vld = pend & ~suppress;
        if (pend && suppress) suppress = 1'b0;
        key_data = pend ? key_of(paddr) : 64'hDEAD_BEEF_DEAD_BEEF;
        pend  = key_rd_en;
        paddr = key_addr;
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cyc();
        tests++;
        if ({req_ready, rsp_valid, rsp_err, key_rd_en, keys_ready, proto_err} !== '0 || key_addr !== '0 || rsp_data !== '0) begin
            fails++;
            $display("FAIL reset_outputs: ready=%b rsp=%b err=%b rd=%b kr=%b pe=%b addr=%0d data=%h, required all zero",
                     req_ready, rsp_valid, rsp_err, key_rd_en, keys_ready, proto_err, key_addr, rsp_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        key_mem_full = 1'b1;
        req_valid = 2'b01;
        req_addr = {9'd0, 9'd5};
        #1;
        tests++;
        if (req_ready !== 2'b00 || keys_ready !== 1'b0) begin
            fails++; $display("FAIL basic_no_key: ready=%b kr=%b, required 00/0", req_ready, keys_ready);
        end
        cyc();
        tests++;
        if (req_ready !== 2'b01 || keys_ready !== 1'b1) begin
            fails++; $display("FAIL basic_grant: ready=%b kr=%b, required 01/1", req_ready, keys_ready);
        end
        cyc();
        req_valid = 2'b00;
        #1;
        tests++;
        if (key_rd_en !== 1'b1 || key_addr !== 9'd5) begin
            fails++; $display("FAIL basic_read: rd=%b addr=%0d, required 1/5", key_rd_en, key_addr);
        end
        cyc();
        tests++;
        if (key_rd_en !== 1'b0 || rsp_valid !== 2'b00) begin
            fails++; $display("FAIL basic_idle: rd=%b rsp=%b, required 0/00", key_rd_en, rsp_valid);
        end
        cyc();
        tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== 64'h0123456789ABCDEF || rsp_err !== 1'b0) begin
            fails++; $display("FAIL basic_rsp: rsp=%b data=%h err=%b, required 01/0123456789abcdef/0", rsp_valid, rsp_data, rsp_err);
        end
        cyc();
        tests++;
        if (rsp_valid !== 2'b00 || rsp_data !== 64'h0123456789ABCDEF) begin
            fails++; $display("FAIL basic_hold: rsp=%b data=%h, required 00/0123456789abcdef", rsp_valid, rsp_data);
        end
    endtask

    task automatic test_alternate();
        int n0 = 0;
        int n1 = 0;
        int r0 = 0;
        int r1 = 0;
        bit rr = 1'b1;
        logic [1:0] exp_g, exp_rsp;
        exp_t q[$];
        exp_t e;
        for (int c = 0; c < 400 && (r0 < 72 || r1 < 72); c++) begin
            req_valid = {n1 < 72, n0 < 72};
            req_addr = {9'(71 - n1), 9'(n0)};
            #1;
            exp_g = (req_valid == 2'b11) ? ((FIXED || !rr) ? 2'b01 : 2'b10) : req_valid;
            tests++;
            if (req_ready !== exp_g) begin
                fails++; $display("FAIL alt_grant c=%0d: ready=%b, required %b", c, req_ready, exp_g);
            end
            if (q.size() > 0 && q[0].due == c) begin
                e = q.pop_front();
                exp_rsp = 2'(1 << e.idx);
                tests++;
                if (rsp_valid !== exp_rsp || rsp_data !== e.data || rsp_err !== 1'b0) begin
                    fails++; $display("FAIL alt_rsp c=%0d: rsp=%b data=%h err=%b, required %b/%h/0", c, rsp_valid, rsp_data, rsp_err, exp_rsp, e.data);
                end
                if (e.idx == 0) r0++; else r1++;
            end else begin
                tests++;
                if (rsp_valid !== 2'b00) begin
                    fails++; $display("FAIL alt_quiet c=%0d: rsp=%b, required 00", c, rsp_valid);
                end
            end
            if (exp_g[0]) begin
                q.push_back('{c + 3, 0, key_of(9'(n0))});
                n0++;
                rr = 1'b1;
            end
            if (exp_g[1]) begin
                q.push_back('{c + 3, 1, key_of(9'(71 - n1))});
                n1++;
                rr = 1'b0;
            end
            cyc();
        end
        req_valid = 2'b00;
        tests++;
        if (r0 != 72 || r1 != 72) begin
            fails++; $display("FAIL alt_count: got %0d/%0d responses, required 72/72", r0, r1);
        end
    endtask

    task automatic test_out_of_range();
        cyc();
        req_valid = 2'b10;
        req_addr = {9'd72, 9'd0};
        #1;
        tests++;
        if (req_ready !== 2'b10) begin
            fails++; $display("FAIL oor_grant: ready=%b, required 10", req_ready);
        end
        cyc();
        req_valid = 2'b01;
        req_addr = {9'd72, 9'd10};
        #1;
        tests++;
        if (req_ready !== 2'b01 || key_rd_en !== 1'b0) begin
            fails++; $display("FAIL oor_no_read: ready=%b rd=%b, required 01/0", req_ready, key_rd_en);
        end
        cyc();
        req_valid = 2'b00;
        #1;
        tests++;
        if (key_rd_en !== 1'b1 || key_addr !== 9'd10) begin
            fails++; $display("FAIL oor_nb_read: rd=%b addr=%0d, required 1/10", key_rd_en, key_addr);
        end
        cyc();
        tests++;
        if (rsp_valid !== 2'b10 || rsp_err !== 1'b1 || rsp_data !== 64'd0) begin
            fails++; $display("FAIL oor_rsp: rsp=%b err=%b data=%h, required 10/1/0", rsp_valid, rsp_err, rsp_data);
        end
        cyc();
        tests++;
        if (rsp_valid !== 2'b01 || rsp_err !== 1'b0 || rsp_data !== key_of(9'd10)) begin
            fails++; $display("FAIL oor_nb_rsp: rsp=%b err=%b data=%h, required 01/0/%h", rsp_valid, rsp_err, rsp_data, key_of(9'd10));
        end
        cyc();
        tests++;
        if (rsp_valid !== 2'b00 || rsp_err !== 1'b0 || proto_err !== 1'b0) begin
            fails++; $display("FAIL oor_quiet: rsp=%b err=%b pe=%b, required 00/0/0", rsp_valid, rsp_err, proto_err);
        end
    endtask

    task automatic test_drain();
        logic [1:0]  g_first = FIXED ? 2'b01 : 2'b10;
        logic [63:0] d_first = FIXED ? key_of(9'd20) : key_of(9'd30);
        req_valid = 2'b11;
        req_addr = {9'd30, 9'd20};
        #1;
        tests++;
        if (req_ready !== g_first) begin
            fails++; $display("FAIL drain_grant_t: ready=%b, required %b", req_ready, g_first);
        end
        cyc();
        key_compute_start = 1'b1;
        key_mem_full = 1'b0;
        #1;
        tests++;
        if (req_ready !== 2'b01 || keys_ready !== 1'b1) begin
            fails++; $display("FAIL drain_grant_t1: ready=%b kr=%b, required 01/1", req_ready, keys_ready);
        end
        cyc();
        key_compute_start = 1'b0;
        #1;
        tests++;
        if (req_ready !== 2'b00 || keys_ready !== 1'b0) begin
            fails++; $display("FAIL drain_blocked: ready=%b kr=%b, required 00/0", req_ready, keys_ready);
        end
        cyc();
        tests++;
        if (rsp_valid !== g_first || rsp_data !== d_first || rsp_err !== 1'b0) begin
            fails++; $display("FAIL drain_rsp1: rsp=%b data=%h err=%b, required %b/%h/0", rsp_valid, rsp_data, rsp_err, g_first, d_first);
        end
        cyc();
        tests++;
        if (rsp_valid !== 2'b01 || rsp_data !== key_of(9'd20)) begin
            fails++; $display("FAIL drain_rsp2: rsp=%b data=%h, required 01/%h", rsp_valid, rsp_data, key_of(9'd20));
        end
        repeat (4) begin
            cyc();
            tests++;
            if (req_ready !== 2'b00 || keys_ready !== 1'b0 || rsp_valid !== 2'b00) begin
                fails++; $display("FAIL drain_no_key: ready=%b kr=%b rsp=%b, required 00/0/00", req_ready, keys_ready, rsp_valid);
            end
        end
        key_mem_full = 1'b1;
        #1;
        tests++;
        if (req_ready !== 2'b00) begin
            fails++; $display("FAIL drain_refill_wait: ready=%b, required 00", req_ready);
        end
        cyc();
        tests++;
        if (req_ready !== g_first || keys_ready !== 1'b1) begin
            fails++; $display("FAIL drain_regrant: ready=%b kr=%b, required %b/1", req_ready, keys_ready, g_first);
        end
        cyc();
        req_valid = 2'b00;
        cyc();
        cyc();
        tests++;
        if (rsp_valid !== g_first || rsp_data !== d_first) begin
            fails++; $display("FAIL drain_regrant_rsp: rsp=%b data=%h, required %b/%h", rsp_valid, rsp_data, g_first, d_first);
        end
        cyc();
    endtask

    task automatic test_proto_err();
        req_valid = 2'b01;
        req_addr = {9'd0, 9'd3};
        suppress = 1'b1;
        #1;
        tests++;
        if (req_ready !== 2'b01 || proto_err !== 1'b0) begin
            fails++; $display("FAIL proto_grant: ready=%b pe=%b, required 01/0", req_ready, proto_err);
        end
        cyc();
        req_valid = 2'b00;
        cyc();
        tests++;
        if (proto_err !== 1'b0) begin
            fails++; $display("FAIL proto_early: pe=%b, required 0", proto_err);
        end
        cyc();
        tests++;
        if (proto_err !== 1'b1 || rsp_valid !== 2'b01 || rsp_data !== key_of(9'd3)) begin
            fails++; $display("FAIL proto_set: pe=%b rsp=%b data=%h, required 1/01/%h", proto_err, rsp_valid, rsp_data, key_of(9'd3));
        end
        repeat (5) cyc();
        tests++;
        if (proto_err !== 1'b1) begin
            fails++; $display("FAIL proto_sticky: pe=%b, required 1", proto_err);
        end
        rst = 1'b1;
        cyc();
        tests++;
        if (proto_err !== 1'b0 || keys_ready !== 1'b0 || rsp_data !== 64'd0) begin
            fails++; $display("FAIL proto_clear: pe=%b kr=%b data=%h, required 0/0/0", proto_err, keys_ready, rsp_data);
        end
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_alternate();
        test_out_of_range();
        test_drain();
        test_proto_err();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
